// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory request/response interface.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W_DEFAULT  = 16;
    localparam int unsigned MEM_DATA_W_DEFAULT  = 16;
    localparam int unsigned MEM_DEPTH_DEFAULT   = 32768;
    localparam int unsigned MEM_LATENCY_DEFAULT = 4;

    // Request as seen on the MEM-stage interface (default widths).
    typedef struct packed {
        logic                          en;
        logic                          wr;
        logic [MEM_ADDR_W_DEFAULT-1:0] addr;
        logic [MEM_DATA_W_DEFAULT-1:0] wdata;
    } mem_req_t;

    // Read response (default widths).
    typedef struct packed {
        logic                          valid;
        logic [MEM_DATA_W_DEFAULT-1:0] data;
        logic [MEM_ADDR_W_DEFAULT-1:0] addr;
    } mem_rsp_t;

endpackage

// File: rtl/mem_latency_pipe.sv
// Fixed-depth valid/payload shift register that delays read responses.
// The last stage is the registered output; any_valid covers every stage.
module mem_latency_pipe
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY   = MEM_LATENCY_DEFAULT,
    parameter int unsigned PAYLOAD_W = MEM_DATA_W_DEFAULT + MEM_ADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 any_valid
);

    logic [LATENCY-1:0]                valid_q, valid_d;
    logic [LATENCY-1:0][PAYLOAD_W-1:0] payload_q, payload_d;

    // Shift one stage per cycle; empty slots carry an all-zero payload so the
    // output reads 0 whenever it is not valid.
    always_comb begin
        valid_d      = '0;
        payload_d    = '0;
        valid_d[0]   = in_valid;
        payload_d[0] = in_valid ? in_payload : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            valid_d[i]   = valid_q[i-1];
            payload_d[i] = payload_q[i-1];
        end
    end

    // Stage registers with synchronous clear that drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q   <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign out_valid   = valid_q[LATENCY-1];
    assign out_payload = payload_q[LATENCY-1];
    assign any_valid   = |valid_q;

endmodule

// File: rtl/data_mem_responder.sv
// Pipelined fixed-latency word memory answering data-memory requests.
// Optional build macro MISALIGN_CHECK_EN adds rsp_err and drops odd-address
// writes; without it address bit 0 is simply ignored.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W  = MEM_DATA_W_DEFAULT,
    parameter int unsigned DEPTH   = MEM_DEPTH_DEFAULT,
    parameter int unsigned LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
`ifdef MISALIGN_CHECK_EN
    output logic              rsp_err,
`endif
    output logic              busy
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MISALIGN_CHECK_EN
    localparam int unsigned PAYLOAD_W = 1 + DATA_W + ADDR_W;
`else
    localparam int unsigned PAYLOAD_W = DATA_W + ADDR_W;
`endif

    logic [DATA_W-1:0]    mem_q [DEPTH];
    logic [ADDR_W-2:0]    word_addr;
    logic [IDX_W-1:0]     idx;
    logic                 wr_en;
    logic                 rd_en;
    logic [DATA_W-1:0]    rd_data;
    logic [PAYLOAD_W-1:0] pipe_in;
    logic [PAYLOAD_W-1:0] pipe_out;
    logic                 pipe_out_valid;
    logic                 pipe_any_valid;
`ifdef MISALIGN_CHECK_EN
    logic                 misaligned;
`endif

    // Decode request into word index and read/write strobes; rst masks both.
    always_comb begin
        word_addr = req_addr[ADDR_W-1:1];
        idx       = IDX_W'(32'(word_addr) % DEPTH);
        wr_en     = req_en & req_wr & ~rst;
        rd_en     = req_en & ~req_wr & ~rst;
        rd_data   = mem_q[idx];
`ifdef MISALIGN_CHECK_EN
        misaligned = req_addr[0];
        if (misaligned) begin
            wr_en   = 1'b0;
            rd_data = '0;
        end
        pipe_in = {misaligned, rd_data, req_addr};
`else
        pipe_in = {rd_data, req_addr};
`endif
    end

    // Storage array; deliberately not reset. A same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= req_wdata;
        end
    end

    mem_latency_pipe #(
        .LATENCY   (LATENCY),
        .PAYLOAD_W (PAYLOAD_W)
    ) u_pipe (
        .clk         (clk),
        .clr         (rst),
        .in_valid    (rd_en),
        .in_payload  (pipe_in),
        .out_valid   (pipe_out_valid),
        .out_payload (pipe_out),
        .any_valid   (pipe_any_valid)
    );

    assign rsp_valid = pipe_out_valid;
    assign rsp_addr  = pipe_out[ADDR_W-1:0];
    assign rsp_data  = pipe_out[ADDR_W +: DATA_W];
    assign busy      = pipe_any_valid;
`ifdef MISALIGN_CHECK_EN
    assign rsp_err   = pipe_out[PAYLOAD_W-1];
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table of requests plus
// hand-written reset/misalign sequences and a random phase, all checked by a
// per-cycle scoreboard monitor.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int unsigned LAT   = MEM_LATENCY_DEFAULT;
    localparam int unsigned DEPTH = MEM_DEPTH_DEFAULT;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_en;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        busy;
`ifdef MISALIGN_CHECK_EN
    logic        rsp_err;
`endif

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_en    (req_en),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
`ifdef MISALIGN_CHECK_EN
        .rsp_err   (rsp_err),
`endif
        .busy      (busy)
    );

    typedef struct {
        mem_rsp_t rsp;
        logic     err;
        int       issue;
    } exp_t;

    typedef struct {
        mem_req_t    req;
        logic [15:0] exp;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] model[int];
    vec_t        tbl[$];
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock and check all outputs against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        check("busy", {31'd0, busy}, {31'd0, (sb.size() > 0 && sb[0].issue < cyc)});
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_cycle", cyc, e.issue + LAT);
                check("rsp_data", {16'd0, rsp_data}, {16'd0, e.rsp.data});
                check("rsp_addr", {16'd0, rsp_addr}, {16'd0, e.rsp.addr});
`ifdef MISALIGN_CHECK_EN
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
`endif
            end
        end else begin
            check("idle_rsp_data", {16'd0, rsp_data}, 32'd0);
            check("idle_rsp_addr", {16'd0, rsp_addr}, 32'd0);
`ifdef MISALIGN_CHECK_EN
            check("idle_rsp_err", {31'd0, rsp_err}, 32'd0);
`endif
            if (sb.size() > 0 && sb[0].issue + LAT <= cyc) begin
                check("rsp_valid_missing", {31'd0, rsp_valid}, 32'd1);
                void'(sb.pop_front());
            end
        end
    endtask

    // Drive one request for one cycle; reads push their expected response.
    task automatic issue(input logic en, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_data,
                         input logic exp_err);
        exp_t e;
        req_en    = en;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        if (rst) begin
            sb.delete();
        end else if (en && !wr) begin
            e.rsp   = '{valid: 1'b1, data: exp_data, addr: addr};
            e.err   = exp_err;
            e.issue = cyc;
            sb.push_back(e);
        end
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    function automatic vec_t mk(input logic en, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] exp);
        vec_t v;
        v.req = '{en: en, wr: wr, addr: addr, wdata: wdata};
        v.exp = exp;
        return v;
    endfunction

    function automatic int widx(input logic [15:0] addr);
        return int'({16'd0, addr} >> 1) % int'(DEPTH);
    endfunction

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        req_en   = 1'b0;
        req_wr   = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        idle(3);
        rst = 1'b0;
        idle(10);

        // Back-to-back request table; reads carry their expected data.
        tbl.push_back(mk(1, 1, 16'h0010, 16'hBEEF, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0010, 16'h0,    16'hBEEF));
        tbl.push_back(mk(0, 0, 16'h0,    16'h0,    16'h0));
        tbl.push_back(mk(1, 1, 16'h0000, 16'h1111, 16'h0));
        tbl.push_back(mk(1, 1, 16'h0002, 16'h2222, 16'h0));
        tbl.push_back(mk(1, 1, 16'h0004, 16'h3333, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0000, 16'h0,    16'h1111));
        tbl.push_back(mk(1, 0, 16'h0002, 16'h0,    16'h2222));
        tbl.push_back(mk(1, 0, 16'h0004, 16'h0,    16'h3333));
        tbl.push_back(mk(1, 1, 16'h0020, 16'hAAAA, 16'h0));
        tbl.push_back(mk(0, 0, 16'h0,    16'h0,    16'h0));
        tbl.push_back(mk(1, 0, 16'h0020, 16'h0,    16'hAAAA));
        tbl.push_back(mk(1, 1, 16'h0020, 16'h5555, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0020, 16'h0,    16'h5555));
        tbl.push_back(mk(1, 0, 16'h0000, 16'h0,    16'h1111));
`ifndef MISALIGN_CHECK_EN
        tbl.push_back(mk(1, 1, 16'h0013, 16'h7777, 16'h0));
        tbl.push_back(mk(1, 0, 16'h0012, 16'h0,    16'h7777));
        tbl.push_back(mk(1, 0, 16'h0013, 16'h0,    16'h7777));
`endif
        foreach (tbl[i]) begin
            issue(tbl[i].req.en, tbl[i].req.wr, tbl[i].req.addr, tbl[i].req.wdata,
                  tbl[i].exp, 1'b0);
        end
        idle(LAT + 2);

`ifdef MISALIGN_CHECK_EN
        // Odd-address write is dropped; odd-address read returns err with zero data.
        issue(1, 1, 16'h0012, 16'h6666, 16'h0, 1'b0);
        issue(1, 1, 16'h0013, 16'h7777, 16'h0, 1'b0);
        issue(1, 0, 16'h0012, 16'h0, 16'h6666, 1'b0);
        issue(1, 0, 16'h0011, 16'h0, 16'h0000, 1'b1);
        idle(LAT + 2);
`endif

        // Reset with two reads in flight and a write presented during reset.
        issue(1, 0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        issue(1, 0, 16'h0000, 16'h0, 16'h1111, 1'b0);
        rst = 1'b1;
        issue(1, 1, 16'h0010, 16'hDEAD, 16'h0, 1'b0);
        rst = 1'b0;
        idle(LAT + 2);
        issue(1, 0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        idle(LAT + 2);

        // Random mix over a small window, checked against a word model.
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a;
            logic [15:0] d;
            a = 16'h0100 + 16'(2 * i);
            d = 16'($urandom);
            model[widx(a)] = d;
            issue(1, 1, a, d, 16'h0, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            logic        en;
            logic        wr;
            logic [15:0] a;
            logic [15:0] d;
            en = ($urandom_range(0, 9) < 8);
            wr = ($urandom_range(0, 9) < 3);
            a  = 16'h0100 + 16'($urandom_range(0, 31));
`ifdef MISALIGN_CHECK_EN
            a[0] = 1'b0;
`endif
            d  = 16'($urandom);
            if (en && !wr) begin
                issue(1, 0, a, 16'h0, model[widx(a)], 1'b0);
            end else begin
                if (en) model[widx(a)] = d;
                issue(en, wr, a, d, 16'h0, 1'b0);
            end
        end
        idle(LAT + 2);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the pipeline's data-memory request interface. Replaces the single-cycle data memory with a pipelined, fixed-latency word memory ahead of the Phase-3 cache work. Accepts one read or write request per cycle and returns read data exactly LATENCY cycles later, tagged with the request address. Sits below the MEM stage; a later cache fill FSM uses it as backing store.

Parameters:
ADDR_W, 16, byte address width of requests.
DATA_W, 16, word width.
DEPTH, 32768, number of words stored; index = req_addr[ADDR_W-1:1] modulo DEPTH.
LATENCY, 4, cycles from read acceptance to rsp_valid; legal range 1..8.

Ports:
clk  in  1  system clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
req_en  in  1  request present this cycle; always accepted, no backpressure.
req_wr  in  1  1 = write, 0 = read; ignored when req_en=0.
req_addr  in  ADDR_W  byte address; bit 0 ignored for indexing.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  read response valid for exactly one cycle.
rsp_data  out  DATA_W  read data; 0 when rsp_valid=0.
rsp_addr  out  ADDR_W  address of the request being answered; 0 when rsp_valid=0.
busy  out  1  1 while any accepted read has not yet responded.

Behaviour:
- Reset: rsp_valid=0, rsp_data=0, rsp_addr=0, busy=0; all latency-pipeline valid bits cleared. Array contents are NOT cleared by reset.
- Reset mid-operation: in-flight reads are discarded, never responded. A request presented in a cycle with rst=1 is ignored, including writes.
- Write: req_en=1, req_wr=1 commits req_wdata to mem[index] at that clock edge. No response is generated.
- Read: req_en=1, req_wr=0 samples mem[index] at the acceptance edge, before any same-edge write to that index. This can only come from an earlier request. The {data, addr} pair enters a LATENCY-deep valid/data shift pipeline.
- Response timing: read accepted at edge N gives rsp_valid=1 with its data and address during the cycle after edge N+LATENCY-1. That is LATENCY cycles after the request cycle. Responses are in issue order.
- Throughput: back-to-back reads every cycle yield back-to-back responses; no bubbles are inserted.
- Ordering: a read issued the cycle after a write to the same index returns the new data. Reads already in flight are unaffected by later writes.
- busy = OR of the pipeline valid bits, registered outputs included.
- Address wrap: index bits above log2(DEPTH) are dropped; no error.
- Outputs are registered, with no combinational path from req_* to rsp_*.

Optional Feature:
MISALIGN_CHECK_EN.
- Defined: adds output port rsp_err (1 bit, reset 0). A read with req_addr[0]=1 still responds after LATENCY cycles, with rsp_err=1 and rsp_data=0. A write with req_addr[0]=1 is dropped and the array is left unchanged.
- Undefined: no rsp_err port; bit 0 is silently ignored for both reads and writes.

Decomposition:
- Shared package mem_pkg:
  - ADDR_W/DATA_W defaults.
  - MEM_LATENCY_DEFAULT=4.
  - Typedef mem_req_t {en, wr, addr, wdata}.
  - Typedef mem_rsp_t {valid, data, addr}.
- One sub-module, mem_latency_pipe: a parameterised LATENCY-stage shift register of {valid, data, addr}, with synchronous clear and an any_valid output that drives busy. The top module holds the array, the indexing, and the write/read sampling.

Test Plan:
- Reset, then idle 10 cycles -> rsp_valid=0, busy=0, rsp_data=0 throughout.
- Write 0xBEEF @0x0010 at cycle 1; read @0x0010 at cycle 2 -> rsp_valid=1 in cycle 6 only, rsp_data=0xBEEF, rsp_addr=0x0010; busy high in cycles 3-6.
- Writes 0x1111/0x2222/0x3333 @0x0/0x2/0x4, then reads of those addresses in 3 consecutive cycles -> 3 consecutive responses 0x1111, 0x2222, 0x3333 in order, with matching rsp_addr.
- Read @0x0020 (holds 0xAAAA), then write 0x5555 @0x0020 the next cycle -> response 0xAAAA; a subsequent read returns 0x5555.
- Two reads in flight, assert rst for 1 cycle -> no rsp_valid ever appears for them; busy=0 the cycle after reset; a write during rst does not change memory.
- With MISALIGN_CHECK_EN: read @0x0011 -> rsp_err=1, rsp_data=0 after 4 cycles. Write 0x7777 @0x0013 -> read @0x0012 returns the prior value.
